// File: rtl/adder_seq_pkg.sv
// Shared constants and state type for the adder operand sequencer.
package adder_seq_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_ADD = 2'd2,
        S_RES = 2'd3
    } state_t;

endpackage

// File: rtl/adder_operand_sequencer.sv
// Loads A then B from a shared byte bus, holds them for the external adder, captures {cout,sum}.
// Latency: B accepted at edge N -> res_valid sampled high at edge N+2; result held until res_ready.
module adder_operand_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             acc_mode,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_valid,
    input  logic             res_ready
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        case (state_q)
            S_A: begin
                if (in_valid) begin
                    op_a_d  = in_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (in_valid) begin
                    op_b_d  = in_data;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                res_sum_d  = sum_in;
                res_cout_d = cout_in;
                state_d    = S_RES;
            end
            S_RES: begin
                // Accumulate reloads A with the sum only; the carry lives on in res_cout.
                if (res_ready) begin
                    if (acc_mode) begin
                        op_a_d  = res_sum_q;
                        state_d = S_B;
                    end else begin
                        state_d = S_A;
                    end
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
        end
    end

    // Handshake outputs decode from state only, so no input reaches them combinationally.
    assign in_ready  = (state_q == S_A) || (state_q == S_B);
    assign res_valid = (state_q == S_RES);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Scoreboarded bench: driver pushes expected A+B per operand pair, monitor pops on each result handshake.
module tb_adder_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       acc_mode = 1'b0;
    logic [7:0] op_a, op_b, sum_in, res_sum;
    logic       cout_in, res_cout, res_valid;
    logic       res_ready = 1'b0;
    logic [8:0] add_full;

    int tests = 0;
    int fails = 0;
    bit rdy_rand = 1'b0;

    logic [8:0] exp_q[$];
    bit         prev_acc = 1'b0;
    logic [7:0] prev_sum = 8'h00;

    always #5 clk = ~clk;

    // Behavioural stand-in for the carry-select adder.
    assign add_full = {1'b0, op_a} + {1'b0, op_b};
    assign sum_in   = add_full[7:0];
    assign cout_in  = add_full[8];

    adder_operand_sequencer #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .acc_mode (acc_mode),
        .op_a     (op_a),
        .op_b     (op_b),
        .sum_in   (sum_in),
        .cout_in  (cout_in),
        .res_sum  (res_sum),
        .res_cout (res_cout),
        .res_valid(res_valid),
        .res_ready(res_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every result handshake must match the oldest expected {cout,sum}.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {23'd0, res_cout, res_sum}, 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {23'd0, res_cout, res_sum}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic gap(input bit en);
        int n;
        n = en ? $urandom_range(0, 2) : 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a posedge; returns just after the transfer edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // One operand pair; acc selects accumulate at this result's handshake.
    task automatic tx(input logic [7:0] a, input logic [7:0] b, input bit acc, input bit gaps);
        logic [7:0] ae;
        if (prev_acc) begin
            ae = prev_sum;
        end else begin
            gap(gaps);
            send(a);
            ae = a;
        end
        exp_q.push_back({1'b0, ae} + {1'b0, b});
        gap(gaps);
        send(b);
        acc_mode = acc;
        prev_acc = acc;
        prev_sum = ae + b;
    endtask

    task automatic wait_valid();
        int n = 0;
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1) break;
            n++;
            if (n > 50) begin
                check("valid_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; holds rst across two edges and checks the cleared outputs.
    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_op_a"}, op_a, 32'h0);
        check({tag, "_op_b"}, op_b, 32'h0);
        check({tag, "_res_sum"}, res_sum, 32'h0);
        check({tag, "_res_cout"}, res_cout, 32'h0);
        check({tag, "_res_valid"}, res_valid, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        prev_acc = 1'b0;
        acc_mode = 1'b0;
        @(negedge clk);
        check({tag, "_in_ready_after"}, in_ready, 32'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset_pulse("reset");

        // Result registered one edge after S_ADD, so sampled high at edge N+2 and for one cycle only.
        res_ready = 1'b1;
        tx(8'h3C, 8'h05, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_valid_n1", res_valid, 32'h0);
        check("lat_in_ready_add", in_ready, 32'h0);
        @(negedge clk);
        check("lat_valid_n2", res_valid, 32'h1);
        check("lat_sum", res_sum, 32'h41);
        @(negedge clk);
        check("lat_valid_n3", res_valid, 32'h0);
        @(posedge clk);
        #1;

        tx(8'hFF, 8'h01, 1'b0, 1'b0);
        tx(8'h80, 8'h80, 1'b0, 1'b0);
        drain();

        // Backpressure: result and in_ready frozen, in_valid pulses ignored.
        res_ready = 1'b0;
        tx(8'h3C, 8'h05, 1'b0, 1'b0);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = (k % 2 == 0);
            in_data  = 8'h77;
            @(negedge clk);
            check("bp_valid", res_valid, 32'h1);
            check("bp_sum", res_sum, 32'h41);
            check("bp_cout", res_cout, 32'h0);
            check("bp_in_ready", in_ready, 32'h0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        drain();
        tx(8'h01, 8'h02, 1'b0, 1'b0);
        drain();

        // Accumulate: second pair supplies only B.
        tx(8'h10, 8'h20, 1'b1, 1'b0);
        tx(8'h00, 8'hF0, 1'b0, 1'b0);
        drain();

        // Reset while A is loaded: the next byte must be treated as A.
        send(8'h55);
        @(negedge clk);
        check("mid_op_a_loaded", op_a, 32'h55);
        @(posedge clk);
        #1;
        reset_pulse("mid_reset");
        tx(8'h01, 8'h02, 1'b0, 1'b0);
        drain();

        // Reset drops a pending result.
        res_ready = 1'b0;
        tx(8'h12, 8'h34, 1'b0, 1'b0);
        wait_valid();
        check("pend_sum", res_sum, 32'h46);
        @(posedge clk);
        #1;
        reset_pulse("pend_reset");

        rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tx(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
        end
        drain();
        rdy_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
